// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - button debounce, RUN/EDIT field select, inc/dec command and blink control
// Optional auto-repeat of held inc/dec buttons: CLOCK_SET_AUTOREPEAT_EN.
module clock_set_ctrl #(
  parameter int DEBOUNCE_CYC     = 1_000_000,
  parameter int REPEAT_DELAY_CYC = 25_000_000,
  parameter int REPEAT_RATE_CYC  = 6_250_000,
  parameter int BLINK_CYC        = 12_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw_mode,
  input  logic       butt_change,
  input  logic       butt_increase,
  input  logic       butt_decrease,
  output logic       edit_active,
  output logic [2:0] field_id,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       led0,
  output logic       led1,
  output logic [7:0] blink_mask
);

  typedef enum logic [1:0] {ST_RUN = 2'b00, ST_EDIT1 = 2'b01, ST_EDIT2 = 2'b10, ST_EDIT3 = 2'b11} state_t;

  localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam int BLK_W = $clog2(BLINK_CYC + 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_CYC - 1);

  // Button index: 0 change, 1 increase, 2 decrease; all active-low.
  logic [2:0]      w_raw;
  logic [2:0]      r_sync1, r_sync2, r_acc, r_acc_d, r_press;
  logic [DB_W-1:0] r_db_cnt [3];
  logic            r_mode_s1, r_mode_s2, r_mode_d;

  assign w_raw = {butt_decrease, butt_increase, butt_change};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= '1;
      r_sync2   <= '1;
      r_acc     <= '1;
      r_acc_d   <= '1;
      r_press   <= '0;
      r_mode_s1 <= 1'b0;
      r_mode_s2 <= 1'b0;
      r_mode_d  <= 1'b0;
      for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1   <= w_raw;
      r_sync2   <= r_sync1;
      r_acc_d   <= r_acc;
      r_press   <= r_acc_d & ~r_acc;
      r_mode_s1 <= sw_mode;
      r_mode_s2 <= r_mode_s1;
      r_mode_d  <= r_mode_s2;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_acc[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_acc[i]    <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  state_t           r_state, w_state_nxt;
  logic             r_edit, r_inc, r_dec, r_phase, w_phase_nxt;
  logic [2:0]       r_field;
  logic [7:0]       r_mask;
  logic [BLK_W-1:0] r_blk_cnt, w_blk_cnt_nxt;
  logic             w_edit_now, w_mode_chg, w_both, w_cmd_ok, w_state_chg;
  logic             w_inc, w_dec, w_rep_inc, w_rep_dec;

  function automatic logic [2:0] f_field(input state_t s, input logic cal);
    f_field = (s == ST_RUN) ? 3'd0 : ({1'b0, s} + (cal ? 3'd3 : 3'd0));
  endfunction

  function automatic logic [7:0] f_digits(input logic [2:0] f);
    case (f)
      3'd1, 3'd4: f_digits = 8'hC0;
      3'd2, 3'd5: f_digits = 8'h30;
      3'd3:       f_digits = 8'h0C;
      3'd6:       f_digits = 8'h0F;
      default:    f_digits = 8'h00;
    endcase
  endfunction

  assign w_edit_now  = (r_state != ST_RUN);
  assign w_mode_chg  = r_mode_s2 ^ r_mode_d;
  assign w_both      = ~r_acc[1] & ~r_acc[2];
  // A change press or a view switch wins over any inc/dec command in the same cycle.
  assign w_cmd_ok    = w_edit_now && !w_mode_chg && !r_press[0] && !w_both;
  assign w_inc       = w_cmd_ok && (r_press[1] || w_rep_inc);
  assign w_dec       = w_cmd_ok && (r_press[2] || w_rep_dec);
  assign w_state_chg = (w_state_nxt != r_state);

  always_comb begin
    w_state_nxt = r_state;
    if (w_edit_now && w_mode_chg) w_state_nxt = ST_RUN;
    else if (r_press[0])          w_state_nxt = state_t'(r_state + 2'd1);
  end

  // Blink phase restarts visible on each field entry and on each command.
  always_comb begin
    w_blk_cnt_nxt = '0;
    w_phase_nxt   = 1'b0;
    if (w_state_nxt != ST_RUN && !w_state_chg && !w_inc && !w_dec) begin
      if (r_blk_cnt == BLK_LAST) begin
        w_phase_nxt = ~r_phase;
      end else begin
        w_blk_cnt_nxt = r_blk_cnt + 1'b1;
        w_phase_nxt   = r_phase;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_edit    <= 1'b0;
      r_field   <= 3'd0;
      r_inc     <= 1'b0;
      r_dec     <= 1'b0;
      r_blk_cnt <= '0;
      r_phase   <= 1'b0;
      r_mask    <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_edit    <= (w_state_nxt != ST_RUN);
      r_field   <= f_field(w_state_nxt, r_mode_s2);
      r_inc     <= w_inc;
      r_dec     <= w_dec;
      r_blk_cnt <= w_blk_cnt_nxt;
      r_phase   <= w_phase_nxt;
      r_mask    <= w_phase_nxt ? f_digits(f_field(w_state_nxt, r_mode_s2)) : 8'h00;
    end
  end

`ifdef CLOCK_SET_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] DLY_LAST  = REP_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [REP_W-1:0] RATE_LAST = REP_W'(REPEAT_RATE_CYC - 1);

  // Index 0 tracks increase, 1 tracks decrease; r_rep_first selects the initial hold delay.
  logic [1:0]       r_rep_act, r_rep_first, w_fire;
  logic [REP_W-1:0] r_rep_cnt [2];

  assign w_fire    = {w_dec, w_inc};
  assign w_rep_inc = r_rep_act[0] && !r_acc[1] &&
                     (r_rep_cnt[0] == (r_rep_first[0] ? DLY_LAST : RATE_LAST));
  assign w_rep_dec = r_rep_act[1] && !r_acc[2] &&
                     (r_rep_cnt[1] == (r_rep_first[1] ? DLY_LAST : RATE_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep_act   <= '0;
      r_rep_first <= '0;
      for (int b = 0; b < 2; b++) r_rep_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (w_fire[b]) begin
          r_rep_cnt[b]   <= '0;
          r_rep_act[b]   <= 1'b1;
          r_rep_first[b] <= r_press[b+1];
        end else if (r_acc[b+1] || !w_edit_now || w_state_chg || w_both) begin
          r_rep_cnt[b] <= '0;
          r_rep_act[b] <= 1'b0;
        end else if (r_rep_act[b]) begin
          r_rep_cnt[b] <= r_rep_cnt[b] + 1'b1;
        end
      end
    end
  end
`else
  assign w_rep_inc = 1'b0;
  assign w_rep_dec = 1'b0;
  // Repeat timing is inert here; the parameters stay so instantiations are build-independent.
  if (REPEAT_DELAY_CYC < 1 || REPEAT_RATE_CYC < 1) begin : g_repeat_inert
  end
`endif

  assign edit_active = r_edit;
  assign field_id    = r_field;
  assign inc_pulse   = r_inc;
  assign dec_pulse   = r_dec;
  assign led0        = r_state[0];
  assign led1        = r_state[1];
  assign blink_mask  = r_mask;

endmodule
